// File: rtl/vsbc_array_if.sv
// Stream-in and result-out handshake bundle for vsbc_array.
interface vsbc_array_if #(
  parameter int NCH     = 4,
  parameter int TW      = 8,
  parameter int MAX_LEN = 256
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic              z_valid;
  logic              z_ready;
  logic [NCH-1:0]    z;
  logic              last;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*TW-1:0] bz;
  logic [LW-1:0]     len_out;
  logic [1:0]        term_cause;

  modport master (
    output z_valid, z, last, out_ready,
    input  z_ready, out_valid, bz, len_out, term_cause
  );

  modport slave (
    input  z_valid, z, last, out_ready,
    output z_ready, out_valid, bz, len_out, term_cause
  );
endinterface

// File: rtl/vsbc_array.sv
// Multi-channel variable-shift binary counter: NCH stochastic streams share one
// weight k; per-beat add/subtract of k, optional halving, saturated results.
module vsbc_array #(
  parameter int NCH     = 4,
  parameter int W       = 4,
  parameter int TW      = 8,
  parameter int MAX_LEN = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] k_init,
  input  logic         bipolar,
  input  logic         rshift,
  output logic         busy,
  vsbc_array_if.slave  io
);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int ACCW = TW + 2 + $clog2(MAX_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Clamp bounds; BMIN is the two's complement of BMAX + 1.
  localparam logic signed [ACCW-1:0] UMAX = (ACCW'(1) << TW) - ACCW'(1);
  localparam logic signed [ACCW-1:0] BMAX = (ACCW'(1) << (TW - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] BMIN = ~BMAX;

  logic [1:0]             state;
  logic [TW:0]            k;
  logic signed [ACCW-1:0] acc [NCH];
  logic [LW-1:0]          cnt;
  logic                   mode;
  logic [1:0]             cause;

  logic                   beat;
  logic signed [ACCW-1:0] k_ext;
  logic [TW:0]            k_nxt;
  logic [LW-1:0]          cnt_nxt;
  logic signed [ACCW-1:0] acc_nxt [NCH];
  logic                   term;
  logic [1:0]             cause_nxt;

  assign beat  = io.z_valid && (state == S_RUN);
  assign k_ext = ACCW'(k);

  assign io.z_ready    = (state == S_RUN);
  assign io.out_valid  = (state == S_HOLD);
  assign busy          = (state == S_RUN) || (state == S_HOLD);
  assign io.len_out    = cnt;
  assign io.term_cause = cause;

  // Next-cycle RUN values: beat update first, then optional halving, then termination.
  always_comb begin
    k_nxt   = rshift ? (k >> 1) : k;
    cnt_nxt = cnt + LW'(beat);
    for (int unsigned i = 0; i < NCH; i++) begin
      acc_nxt[i] = acc[i];
      if (beat) begin
        if (io.z[i])   acc_nxt[i] = acc_nxt[i] + k_ext;
        else if (mode) acc_nxt[i] = acc_nxt[i] - k_ext;
      end
      if (rshift) acc_nxt[i] = acc_nxt[i] >>> 1;
    end
    term      = 1'b0;
    cause_nxt = cause;
    if (beat && io.last) begin
      term      = 1'b1;
      cause_nxt = 2'b00;
    end else if (k_nxt == '0) begin
      term      = 1'b1;
      cause_nxt = 2'b01;
    end else if (cnt_nxt == LW'(MAX_LEN)) begin
      term      = 1'b1;
      cause_nxt = 2'b10;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      cause <= 2'b00;
      for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          k     <= {k_init, {(TW - W + 1){1'b0}}};
          cnt   <= '0;
          mode  <= bipolar;
          for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
        end
        S_RUN: begin
          k   <= k_nxt;
          cnt <= cnt_nxt;
          for (int unsigned i = 0; i < NCH; i++) acc[i] <= acc_nxt[i];
          if (term) begin
            state <= S_HOLD;
            cause <= cause_nxt;
          end
        end
        S_HOLD: if (io.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating conversion of each accumulator to the TW-bit result.
  always_comb begin
    io.bz = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (mode) begin
        if (acc[i] > BMAX)      io.bz[i*TW +: TW] = BMAX[TW-1:0];
        else if (acc[i] < BMIN) io.bz[i*TW +: TW] = BMIN[TW-1:0];
        else                    io.bz[i*TW +: TW] = acc[i][TW-1:0];
      end else begin
        if (acc[i] < 0)         io.bz[i*TW +: TW] = '0;
        else if (acc[i] > UMAX) io.bz[i*TW +: TW] = UMAX[TW-1:0];
        else                    io.bz[i*TW +: TW] = acc[i][TW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_vsbc_array.sv
// Self-checking bench for vsbc_array: directed cases plus random conversions
// compared against an integer-arithmetic reference model.
module tb_vsbc_array;
  localparam int NCH  = 4;
  localparam int W    = 4;
  localparam int TW   = 8;
  localparam int MAXL = 16;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_HOLD = 2;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic [W-1:0] k_init  = '0;
  logic         bipolar = 1'b0;
  logic         rshift  = 1'b0;
  logic         busy;

  vsbc_array_if #(.NCH(NCH), .TW(TW), .MAX_LEN(MAXL)) io ();

  vsbc_array #(.NCH(NCH), .W(W), .TW(TW), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_init(k_init),
    .bipolar(bipolar), .rshift(rshift), .busy(busy), .io(io.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_ph = P_IDLE;
  int m_k = 0;
  int m_cnt = 0;
  int m_cause = 0;
  bit m_bip = 1'b0;
  int macc [NCH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] exp_bz(input int a, input bit bip);
    int lo, hi, c;
    lo = bip ? -(1 << (TW - 1)) : 0;
    hi = bip ? (1 << (TW - 1)) - 1 : (1 << TW) - 1;
    c  = (a < lo) ? lo : ((a > hi) ? hi : a);
    return c[TW-1:0];
  endfunction

  function automatic logic [TW-1:0] bz_ch(input int i);
    logic [NCH*TW-1:0] b;
    b = io.bz;
    return b[i*TW +: TW];
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_k = 0; m_cnt = 0; m_cause = 0; m_bip = 1'b0;
    for (int i = 0; i < NCH; i++) macc[i] = 0;
  endtask

  task automatic compare_all();
    check("z_ready", 64'(io.z_ready), 64'(m_ph == P_RUN));
    check("out_valid", 64'(io.out_valid), 64'(m_ph == P_HOLD));
    check("busy", 64'(busy), 64'(m_ph != P_IDLE));
    check("len_out", 64'(io.len_out), 64'(m_cnt));
    check("term_cause", 64'(io.term_cause), 64'(m_cause));
    for (int i = 0; i < NCH; i++)
      check("bz", 64'(bz_ch(i)), 64'(exp_bz(macc[i], m_bip)));
  endtask

  // Advance the model with the currently driven inputs, clock once, compare.
  task automatic step();
    case (m_ph)
      P_IDLE: if (start) begin
        m_k = int'(k_init) * (1 << (TW - W + 1));
        m_cnt = 0;
        m_bip = bipolar;
        for (int i = 0; i < NCH; i++) macc[i] = 0;
        m_ph = P_RUN;
      end
      P_RUN: begin
        if (io.z_valid) begin
          for (int i = 0; i < NCH; i++)
            if (io.z[i]) macc[i] += m_k;
            else if (m_bip) macc[i] -= m_k;
          m_cnt++;
        end
        if (rshift) begin
          for (int i = 0; i < NCH; i++) macc[i] = macc[i] >>> 1;
          m_k = m_k / 2;
        end
        if (io.z_valid && io.last) begin m_cause = 0; m_ph = P_HOLD; end
        else if (m_k == 0)         begin m_cause = 1; m_ph = P_HOLD; end
        else if (m_cnt == MAXL)    begin m_cause = 2; m_ph = P_HOLD; end
      end
      default: if (io.out_ready) m_ph = P_IDLE;
    endcase
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit st, input bit zv, input logic [NCH-1:0] zz,
                     input bit ls, input bit rs, input bit ordy);
    start = st; io.z_valid = zv; io.z = zz; io.last = ls; rshift = rs; io.out_ready = ordy;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    io.z_valid = 1'b0; io.z = '0; io.last = 1'b0; io.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Unipolar, four beats on ch0, last on the 4th
    k_init = 4'd1; bipolar = 1'b0;
    cyc(1, 0, '0, 0, 0, 0);
    for (int b = 0; b < 4; b++) cyc(0, 1, 4'b0001, b == 3, 0, 0);
    check("tp1_bz0", 64'(bz_ch(0)), 64'd128);
    check("tp1_len", 64'(io.len_out), 64'd4);
    check("tp1_valid", 64'(io.out_valid), 64'd1);
    cyc(0, 0, '0, 0, 0, 1);

    // Shift every beat until k is exhausted
    cyc(1, 0, '0, 0, 0, 0);
    for (int b = 0; b < 10 && m_ph == P_RUN; b++) cyc(0, 1, 4'b0001, 0, 1, 0);
    check("tp2_bz0", 64'(bz_ch(0)), 64'd3);
    check("tp2_len", 64'(io.len_out), 64'd6);
    check("tp2_cause", 64'(io.term_cause), 64'd1);
    cyc(0, 0, '0, 0, 0, 1);

    // Unipolar saturation: 9 beats -> 288
    cyc(1, 0, '0, 0, 0, 0);
    for (int b = 0; b < 9; b++) cyc(0, 1, 4'b0001, b == 8, 0, 0);
    check("tp3_bz0", 64'(bz_ch(0)), 64'd255);
    cyc(0, 0, '0, 0, 0, 1);

    // Bipolar, 5 beats
    bipolar = 1'b1;
    cyc(1, 0, '0, 0, 0, 0);
    for (int b = 0; b < 5; b++) cyc(0, 1, {1'b0, 1'b1, 1'b0, ~b[0]}, b == 4, 0, 0);
    check("tp4_bz0", 64'(bz_ch(0)), 64'h20);
    check("tp4_bz1", 64'(bz_ch(1)), 64'h80);
    check("tp4_bz2", 64'(bz_ch(2)), 64'h7F);
    cyc(0, 0, '0, 0, 0, 1);

    // MAX_LEN termination, output stall, start ignored in HOLD
    bipolar = 1'b0;
    cyc(1, 0, '0, 0, 0, 0);
    for (int b = 0; b < MAXL; b++) cyc(0, 1, 4'b0011, 0, 0, 0);
    check("tp5_cause", 64'(io.term_cause), 64'd2);
    check("tp5_len", 64'(io.len_out), 64'(MAXL));
    for (int h = 0; h < 3; h++) cyc(h == 1, 0, '0, 0, 0, 0);
    check("tp5_hold", 64'(io.out_valid), 64'd1);
    cyc(1, 0, '0, 0, 0, 1);
    check("tp5_idle", 64'(busy), 64'd0);
    cyc(0, 1, 4'b1111, 1, 1, 0);

    // Asynchronous reset mid-RUN
    cyc(1, 0, '0, 0, 0, 0);
    for (int b = 0; b < 3; b++) cyc(0, 1, 4'b0101, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 1, 4'b1001, 0, 0, 0);
    cyc(0, 1, 4'b1001, 1, 0, 0);
    check("tp6_bz0", 64'(bz_ch(0)), 64'd64);
    cyc(0, 0, '0, 0, 0, 1);

    // Random conversions
    for (int n = 0; n < 30; n++) begin
      k_init  = W'($urandom_range(0, (1 << W) - 1));
      bipolar = 1'($urandom_range(0, 1));
      cyc(1, 0, '0, 0, 0, 0);
      for (int c = 0; c < 40 && m_ph == P_RUN; c++)
        cyc(0, 1'($urandom_range(0, 3) != 0), NCH'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, 0);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++)
        cyc(1'($urandom_range(0, 1)), 0, '0, 0, 0, 0);
      cyc(1'($urandom_range(0, 1)), 0, '0, 0, 0, 1);
      cyc(0, 1'($urandom_range(0, 1)), NCH'($urandom), 0, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
